top_latch: RTL and testbench



---
 rtl/top_latch.sv | 130 +++++++++++++
 tb/tb_top_latch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/top_latch.sv
// top_latch: instruction-fetch decompressor turning a packed token stream into one instruction per clock.
// Optional build macro: DECOMP_BYTESWAP_EN (byte-reverses the decoded word). Rev 1.0
`default_nettype none

module top_latch #(
   parameter int unsigned                   DATA_W      = 32,
   parameter logic [DATA_W-1:0]             PC_STEP     = 'h4,
   parameter int unsigned                   TOKEN_W     = 4,
   parameter logic [TOKEN_W-1:0]            ESC_TOKEN   = '1,
   parameter int unsigned                   TABLE_DEPTH = 32,
   parameter int unsigned                   PROG_DEPTH  = 77,
   parameter logic [TABLE_DEPTH*DATA_W-1:0] TABLE_INIT  = '0,
   parameter logic [PROG_DEPTH*DATA_W-1:0]  PROG_INIT   = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] PCcpu,
   output logic [DATA_W-1:0] DecompressInstr
);

   localparam int unsigned   STREAM_BITS    = PROG_DEPTH * DATA_W;
   localparam int unsigned   PW             = $clog2(STREAM_BITS) + 1;
   localparam logic [PW-1:0] W_BITS         = PW'(DATA_W);
   localparam logic [PW-1:0] T_BITS         = PW'(TOKEN_W);
   localparam logic [PW-1:0] LAST_TOKEN_POS = PW'(STREAM_BITS - TOKEN_W);
   localparam logic [PW-1:0] N_WORDS        = PW'(PROG_DEPTH);

   typedef enum logic {SEQ = 1'b0, SEEK = 1'b1} state_t;

   state_t              state_q;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [DATA_W-1:0]   cur_pc_q, instr_q, instr_d;
   logic [DATA_W-1:0]   pc_req, pc_nxt, pc_prev;
   logic [PW-1:0]       word_idx, bit_off;
   logic [3*DATA_W-1:0] window;
   logic [TOKEN_W-1:0]  token;
   logic [DATA_W-1:0]   literal, raw;

   function automatic logic [DATA_W-1:0] prog_word(input logic [PW-1:0] idx);
      logic [DATA_W-1:0] w;
      w = '0;
      if (idx < N_WORDS)
         w = PROG_INIT[idx*DATA_W +: DATA_W];
      return w;
   endfunction

   // Indices past the dictionary fall through to zero.
   function automatic logic [DATA_W-1:0] dict_lookup(input logic [TOKEN_W-1:0] t);
      logic [DATA_W-1:0] w;
      w = '0;
      for (int k = 0; k < int'(TABLE_DEPTH); k++)
         if (int'(t) == k)
            w = TABLE_INIT[k*DATA_W +: DATA_W];
      return w;
   endfunction

   always_comb begin
      pc_req   = PCcpu & ~(PC_STEP - 1'b1);
      pc_nxt   = cur_pc_q + PC_STEP;
      pc_prev  = cur_pc_q - PC_STEP;
      word_idx = ptr_q / W_BITS;
      bit_off  = ptr_q % W_BITS;
      // Three words cover an escape token straddling a boundary plus its literal.
      window   = {prog_word(word_idx), prog_word(word_idx + 1'b1), prog_word(word_idx + PW'(2))};
      token    = window[(3*DATA_W-1) - int'(bit_off) -: TOKEN_W];
      literal  = window[(3*DATA_W-1-TOKEN_W) - int'(bit_off) -: DATA_W];
      raw      = '0;
      ptr_d    = ptr_q;
      if (ptr_q > LAST_TOKEN_POS) begin
         raw   = '0;
         ptr_d = ptr_q;
      end else if (token == ESC_TOKEN) begin
         raw   = literal;
         ptr_d = ptr_q + T_BITS + W_BITS;
      end else begin
         raw   = dict_lookup(token);
         ptr_d = ptr_q + T_BITS;
      end
      instr_d = '0;
`ifdef DECOMP_BYTESWAP_EN
      for (int b = 0; b < int'(DATA_W / 8); b++)
         instr_d[8*b +: 8] = raw[DATA_W-8-8*b +: 8];
`else
      instr_d = raw;
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= SEQ;
         ptr_q    <= '0;
         cur_pc_q <= '0;
         instr_q  <= '0;
      end else begin
         case (state_q)
            SEQ: begin
               if (pc_req == cur_pc_q) begin
                  instr_q  <= instr_d;
                  ptr_q    <= ptr_d;
                  cur_pc_q <= pc_nxt;
               end else if (pc_req != pc_prev) begin
                  state_q <= SEEK;
               end
            end
            SEEK: begin
               if (pc_req < cur_pc_q) begin
                  ptr_q    <= '0;
                  cur_pc_q <= '0;
                  if (pc_req == '0)
                     state_q <= SEQ;
               end else if (pc_req == cur_pc_q) begin
                  state_q <= SEQ;
               end else begin
                  // Leave SEEK on the skip that lands on the target so it decodes next edge.
                  ptr_q    <= ptr_d;
                  cur_pc_q <= pc_nxt;
                  if (pc_nxt == pc_req)
                     state_q <= SEQ;
               end
            end
            default: state_q <= SEQ;
         endcase
      end
   end

   assign DecompressInstr = instr_q;

endmodule

`default_nettype wire

// File: tb/tb_top_latch.sv
// tb_top_latch: scoreboard bench for top_latch; a known instruction list is encoded into the
// ROM images and expected outputs come from that list plus PC-distance timing rules.
`default_nettype none

module tb_top_latch;

   localparam int N_INSTR     = 112;
   localparam int TABLE_DEPTH = 32;
   localparam int PROG_DEPTH  = 77;
   localparam int SBITS       = PROG_DEPTH * 32;

   // Program content: first 14 instructions and every odd one are literals, the rest dictionary words.
   function automatic logic is_esc(input int i);
      return (i < 14) || (i % 2 == 1);
   endfunction

   function automatic logic [31:0] lit(input int i);
      if (i == 1)   return 32'hDEADBEEF;
      if (i == 111) return 32'h1EFF2FE1;
      return (32'(i) * 32'h9E3779B9) ^ 32'h5BD1E995;
   endfunction

   function automatic logic [3:0] tok(input int i);
      return 4'(1 + (i * 5) % 14);
   endfunction

   function automatic logic [31:0] tbl(input int t);
      return (32'(t) * 32'h01020409) ^ 32'hC0DE0000;
   endfunction

   function automatic logic [TABLE_DEPTH*32-1:0] build_table();
      logic [TABLE_DEPTH*32-1:0] img;
      img = '0;
      for (int t = 0; t < TABLE_DEPTH; t++) img[t*32 +: 32] = tbl(t);
      return img;
   endfunction

   function automatic logic [SBITS-1:0] build_prog();
      logic [SBITS-1:0] s;
      logic [SBITS-1:0] img;
      logic [35:0]      f;
      int               pos;
      s   = '0;
      pos = 0;
      for (int i = 0; i < N_INSTR; i++) begin
         if (is_esc(i)) begin
            f = {4'hF, lit(i)};
            for (int b = 0; b < 36; b++) s[SBITS-1-pos-b] = f[35-b];
            pos += 36;
         end else begin
            f = {32'h0, tok(i)};
            for (int b = 0; b < 4; b++) s[SBITS-1-pos-b] = f[3-b];
            pos += 4;
         end
      end
      img = '0;
      for (int w = 0; w < PROG_DEPTH; w++) img[w*32 +: 32] = s[SBITS-1-32*w -: 32];
      return img;
   endfunction

   localparam logic [TABLE_DEPTH*32-1:0] TBL_IMG  = build_table();
   localparam logic [SBITS-1:0]          PROG_IMG = build_prog();

   function automatic logic [31:0] exp_instr(input logic [31:0] p);
      int          i;
      logic [31:0] v;
      i = int'(p >> 2);
      if (i >= N_INSTR) return 32'h0;
      v = is_esc(i) ? lit(i) : tbl(int'(tok(i)));
`ifdef DECOMP_BYTESWAP_EN
      v = {v[7:0], v[15:8], v[23:16], v[31:24]};
`endif
      return v;
   endfunction

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PCcpu;
   logic [31:0] DecompressInstr;

   top_latch #(
      .DATA_W(32), .PC_STEP(32'h4), .TOKEN_W(4), .ESC_TOKEN(4'hF),
      .TABLE_DEPTH(TABLE_DEPTH), .PROG_DEPTH(PROG_DEPTH),
      .TABLE_INIT(TBL_IMG), .PROG_INIT(PROG_IMG)
   ) dut (
      .clk(clk), .reset(reset), .PCcpu(PCcpu), .DecompressInstr(DecompressInstr)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] val;
      logic [31:0] pc;
   } exp_t;

   exp_t        sb[$];
   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] m_next;
   logic [31:0] m_last;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (e.cyc != cyc || DecompressInstr !== e.val) begin
            errors++;
            $display("FAIL instr pc=%h cyc=%0d got %h expected %h", e.pc, cyc, DecompressInstr, e.val);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int ofs, input logic [31:0] v, input logic [31:0] p);
      exp_t e;
      e.cyc = cyc + ofs;
      e.val = v;
      e.pc  = p;
      sb.push_back(e);
   endtask

   // Latency follows from PC distance: 1 edge in sequence, 2 + skips forward, 3 + p/4 after a restart.
   task automatic request(input logic [31:0] p);
      int          lat;
      logic [31:0] v;
      logic        rep;
      rep = (m_next >= 32'h4) && (p == m_next - 32'h4);
      if (p == m_next || rep) lat = 1;
      else if (p > m_next)    lat = 2 + int'((p - m_next) >> 2);
      else                    lat = 3 + int'(p >> 2);
      v = rep ? m_last : exp_instr(p);
      PCcpu = p | 32'($urandom_range(0, 3));
      for (int j = 1; j <= lat; j++) expect_at(j, (j < lat) ? m_last : v, p);
      if (!rep) begin
         m_next = p + 32'h4;
         m_last = v;
      end
      repeat (lat) step();
   endtask

   task automatic do_reset(input int edges);
      reset = 1'b0;
      for (int j = 1; j <= edges; j++) expect_at(j, 32'h0, PCcpu);
      repeat (edges) step();
      reset  = 1'b1;
      m_next = 32'h0;
      m_last = 32'h0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      PCcpu = 32'h0;
      m_next = 32'h0;
      m_last = 32'h0;
      step();
      do_reset(2);

      // Full sequential stream, including escape straddling words 1/2 and the last literal.
      for (int i = 0; i < N_INSTR; i++) request(32'(i * 4));
      request(32'h1C0);
      request(32'h1C4);
      request(32'h1C0);

      // Forward and backward jumps.
      do_reset(1);
      for (int i = 0; i <= 4; i++) request(32'(i * 4));
      request(32'h40);
      request(32'h8);
      request(32'hC);
      request(32'h0);

      // Reset asserted while seeking far forward.
      PCcpu = 32'h100;
      for (int j = 1; j <= 4; j++) expect_at(j, m_last, 32'h100);
      repeat (4) step();
      do_reset(2);
      request(32'h0);

      // Past the end of the stream, reached by seeking.
      request(32'h1F0);
      request(32'h1F4);

      for (int n = 0; n < 80; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 5)
            request((m_next <= 32'h1FC) ? m_next : 32'h0);
         else if (r < 7 && m_next >= 32'h4)
            request(m_next - 32'h4);
         else
            request(32'($urandom_range(0, 127)) << 2);
      end

      repeat (3) step();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
